dot_product_scheduler: RTL and testbench

DOT_PRODUCT_SCHEDULER -- requirements
Module: dot_product_scheduler

---
 rtl/po2_pkg.sv | 23 ++
 rtl/wait_watchdog.sv | 31 +++
 rtl/dot_product_scheduler.sv | 134 +++++++++++++
 tb/tb_dot_product_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/po2_pkg.sv
// Shared types and width helpers for the dot-product scheduler.
//   state_t   : scheduler FSM state encoding
//   row_width : bits needed for a row index over k rows (min 1)
//   wd_width  : bits needed for a watchdog counting 0..t-1 (min 1)
package po2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_STORE,
    S_DONE
  } state_t;

  function automatic int row_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

  function automatic int wd_width(input int t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/wait_watchdog.sv
// Bounds the number of cycles spent waiting for one engine result.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear back to 0
//   en       : count one waiting cycle
//   expired  : high on the TIMEOUT-th waiting cycle (count == TIMEOUT-1)
module wait_watchdog
  import po2_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = wd_width(TIMEOUT);

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(TIMEOUT - 1));

  // Holds at the terminal value so the counter never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (en && !expired)  cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/dot_product_scheduler.sv
// Sequences K weight-set rows of a shared dot-product engine over one
// accepted activation vector and presents all K results together.
//   clk, rst           : clock, asynchronous active-high reset
//   in_data/in_v/in_ready : activation vector input handshake
//   eng_a, eng_row     : operands held stable for the engine per row
//   eng_rst            : engine restart; falling edge starts a dot product
//   eng_out/eng_out_v  : engine result, valid until eng_rst rises again
//   out_data/out_v/out_ready : packed row results (row 0 in the MSBs)
//   err                : sticky engine timeout flag
//
// state | meaning
// IDLE  | ready for a vector, engine held in restart
// START | one restart cycle for the current row, watchdog cleared
// WAIT  | engine running, waiting for eng_out_v or watchdog expiry
// STORE | write row result, advance row or finish
// DONE  | out_data valid, waiting for out_ready
module dot_product_scheduler
  import po2_pkg::*;
#(
  parameter int W       = 16,
  parameter int D       = 4,
  parameter int K       = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [D*W-1:0]          in_data,
  input  logic                    in_v,
  output logic                    in_ready,
  output logic [D*W-1:0]          eng_a,
  output logic [row_width(K)-1:0] eng_row,
  output logic                    eng_rst,
  input  logic [2*W-1:0]          eng_out,
  input  logic                    eng_out_v,
  output logic [K*2*W-1:0]        out_data,
  output logic                    out_v,
  input  logic                    out_ready,
  output logic                    err
);

  localparam int RW = row_width(K);

  state_t         state, state_nxt;
  logic [RW-1:0]  row;
  logic           tmo;
  logic           wd_clr, wd_en, wd_expired;
  logic           timeout;
  logic           slot_we;
  logic [2*W-1:0] slot_val;

  wait_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // A result arriving on the last allowed cycle wins over the timeout.
  assign timeout  = (state == S_WAIT) && !eng_out_v && wd_expired;
  assign slot_we  = timeout || ((state == S_STORE) && !tmo);
  assign slot_val = timeout ? '0 : eng_out;
  assign eng_row  = row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_v) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (eng_out_v || wd_expired) state_nxt = S_STORE;
      S_STORE: state_nxt = (row == RW'(K - 1)) ? S_DONE : S_START;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // eng_rst stays low through STORE so the engine result is still valid
  // when it is written.
  always_comb begin
    in_ready = 1'b0;
    eng_rst  = 1'b1;
    out_v    = 1'b0;
    wd_clr   = 1'b0;
    wd_en    = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        wd_clr   = 1'b1;
      end
      S_START: wd_clr = 1'b1;
      S_WAIT: begin
        eng_rst = 1'b0;
        wd_en   = !eng_out_v;
      end
      S_STORE: eng_rst = 1'b0;
      S_DONE:  out_v = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_a    <= '0;
      row      <= '0;
      tmo      <= 1'b0;
      err      <= 1'b0;
      out_data <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_v) begin
          eng_a <= in_data;
          row   <= '0;
        end
        S_START: tmo <= 1'b0;
        S_WAIT: if (timeout) begin
          err <= 1'b1;
          tmo <= 1'b1;
        end
        S_STORE: if (row != RW'(K - 1)) row <= row + RW'(1);
        default: ;
      endcase
      for (int k = 0; k < K; k++) begin
        if (slot_we && row == RW'(k))
          out_data[2*W*(K-1-k) +: 2*W] <= slot_val;
      end
    end
  end

endmodule

// File: tb/tb_dot_product_scheduler.sv
module tb_dot_product_scheduler;

  localparam int W = 16;
  localparam int D = 4;
  localparam int K = 2;
  localparam int T = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic [D*W-1:0]   in_data;
  logic             in_v;
  logic             in_ready;
  logic [D*W-1:0]   eng_a;
  logic [0:0]       eng_row;
  logic             eng_rst;
  logic [2*W-1:0]   eng_out;
  logic             eng_out_v;
  logic [K*2*W-1:0] out_data;
  logic             out_v;
  logic             out_ready;
  logic             err;

  always #5 clk = ~clk;

  dot_product_scheduler #(.W(W), .D(D), .K(K), .TIMEOUT(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_v      (in_v),
    .in_ready  (in_ready),
    .eng_a     (eng_a),
    .eng_row   (eng_row),
    .eng_rst   (eng_rst),
    .eng_out   (eng_out),
    .eng_out_v (eng_out_v),
    .out_data  (out_data),
    .out_v     (out_v),
    .out_ready (out_ready),
    .err       (err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int hs_cyc = -1;

  typedef struct {
    logic [K*2*W-1:0] data;
    bit               err;
    int               exp_cyc;
  } exp_t;
  exp_t sb[$];

  // Engine configuration: fixed weight sets, per-row latency / hang
  int cfg_lat [K];
  bit cfg_hang [K];
  int wt [K][D];
  bit dot_mode;
  bit err_model;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  function automatic logic [2*W-1:0] eng_func(input int r, input logic [D*W-1:0] a);
    longint s = 0;
    if (!dot_mode) return 32'(100 * r + 7);
    for (int i = 0; i < D; i++)
      s += longint'($signed(a[(D-1-i)*W +: W])) * longint'(wt[r][i]);
    return s[2*W-1:0];
  endfunction

  // Stub engine: result valid lat cycles after eng_rst falls, then held
  // (with the old value) until one cycle after eng_rst rises again.
  int               st_cnt;
  logic             st_v;
  logic [2*W-1:0]   st_res;
  assign eng_out   = st_res;
  assign eng_out_v = st_v;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      st_cnt <= 0;
      st_v   <= 1'b0;
      st_res <= '0;
    end else if (eng_rst) begin
      st_cnt <= 0;
      st_v   <= 1'b0;
    end else if (!st_v && !cfg_hang[eng_row]) begin
      if (st_cnt == cfg_lat[eng_row] - 1) begin
        st_v   <= 1'b1;
        st_res <= eng_func(int'(eng_row), eng_a);
      end else begin
        st_cnt <= st_cnt + 1;
      end
    end
  end

  // Configure the engine for a vector and queue its expected response.
  task automatic cfg_push(input logic [D*W-1:0] vec, input int lat [K], input bit hang [K],
                          input bit dm, input bit push, input int acc);
    exp_t e;
    int   total = 1;
    dot_mode = dm;
    for (int k = 0; k < K; k++) begin
      cfg_lat[k]  = lat[k];
      cfg_hang[k] = hang[k];
    end
    if (!push) return;
    e.data = '0;
    for (int k = 0; k < K; k++) begin
      e.data[2*W*(K-1-k) +: 2*W] = hang[k] ? '0 : eng_func(k, vec);
      total += 2 + (hang[k] ? T : lat[k] + 1);
      if (hang[k]) err_model = 1'b1;
    end
    e.err     = err_model;
    e.exp_cyc = acc + total;
    sb.push_back(e);
  endtask

  task automatic send(input logic [D*W-1:0] vec, input int lat [K], input bit hang [K],
                      input bit dm, input bit push, input bit rnd_ready);
    int n = 0;
    @(negedge clk);
    while (!in_ready) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      n++;
      if (n > 400) begin
        chk("in_ready_wait_timeout", 0, 1);
        finish_sim();
      end
      @(negedge clk);
    end
    in_data = vec;
    in_v    = 1'b1;
    cfg_push(vec, lat, hang, dm, push, cyc);
    @(negedge clk);
    in_v = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        chk("drain_timeout", 0, 1);
        finish_sim();
      end
    end
  endtask

  function automatic logic [D*W-1:0] rand_vec();
    logic [D*W-1:0] v;
    for (int i = 0; i < D; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  // Scoreboard monitor
  initial begin
    logic             prev_v;
    logic [K*2*W-1:0] held;
    exp_t             e;
    prev_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_v = 1'b0;
        continue;
      end
      if (out_v && !prev_v) begin
        held = out_data;
        if (sb.size() == 0) chk("unexpected_out_v", 1, 0);
        else                chk("out_v_latency", cyc, sb[0].exp_cyc);
      end
      if (out_v && prev_v) chk("out_data_hold", out_data, held);
      if (out_v) chk("in_ready_in_done", in_ready, 0);
      if (out_v && out_ready) begin
        hs_cyc = cyc;
        if (sb.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.data);
          chk("err", err, e.err);
        end
      end
      prev_v = out_v;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    finish_sim();
  end

  initial begin
    int               la [K];
    bit               ha [K];
    logic [D*W-1:0]   v;
    int               n;
    int               acc;

    rst       = 1'b0;
    in_v      = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    dot_mode  = 1'b0;
    err_model = 1'b0;
    for (int k = 0; k < K; k++) begin
      cfg_lat[k]  = 1;
      cfg_hang[k] = 1'b0;
      for (int i = 0; i < D; i++) wt[k][i] = int'($urandom_range(0, 2000)) - 1000;
    end
    #1 rst = 1'b1;
    in_data = rand_vec();
    in_v    = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_eng_rst", eng_rst, 1);
    chk("rst_out_v", out_v, 0);
    chk("rst_err", err, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_eng_a", eng_a, 0);
    chk("rst_eng_row", eng_row, 0);
    in_v = 1'b0;
    rst  = 1'b0;

    // Fixed-result engine, L=3: row0=7, row1=107, out_v 13 cycles after accept
    la = '{3, 3}; ha = '{0, 0};
    v = rand_vec();
    send(v, la, ha, 1'b0, 1'b1, 1'b0);
    chk("start_eng_a", eng_a, v);
    chk("start_eng_row", eng_row, 0);
    chk("start_eng_rst", eng_rst, 1);
    chk("start_in_ready", in_ready, 0);
    checks++;
    if (sb.size() != 1 || sb[0].data !== {32'd7, 32'd107}) begin
      errors++;
      $display("FAIL fixed_model_expect: queue entry differs from {7,107}");
    end
    drain();

    // Consumer stalls 5 cycles; a vector offered meanwhile waits for IDLE
    out_ready = 1'b0;
    la = '{2, 5}; ha = '{0, 0};
    send(rand_vec(), la, ha, 1'b1, 1'b1, 1'b0);
    n = 0;
    while (!out_v) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        chk("stall_out_v_timeout", 0, 1);
        finish_sim();
      end
    end
    v       = rand_vec();
    in_data = v;
    in_v    = 1'b1;
    la = '{4, 1}; ha = '{0, 0};
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_v", out_v, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("idle_after_ready", in_ready, 1);
    chk("out_v_dropped", out_v, 0);
    acc = cyc;
    chk("b2b_accept_cycle", acc, hs_cyc + 1);
    cfg_push(v, la, ha, 1'b1, 1'b1, acc);
    @(negedge clk);
    in_v = 1'b0;
    drain();

    // Row 1 never answers: timeout after T waiting cycles, row1=0, err set
    la = '{3, 3}; ha = '{0, 1};
    send(rand_vec(), la, ha, 1'b0, 1'b1, 1'b0);
    drain();

    // Result on the last allowed waiting cycle is taken, not timed out
    la = '{T - 1, 2}; ha = '{0, 0};
    send(rand_vec(), la, ha, 1'b1, 1'b1, 1'b0);
    drain();

    // Reset during row 1 WAIT aborts the vector and clears err
    la = '{3, 3}; ha = '{0, 0};
    send(rand_vec(), la, ha, 1'b0, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_out_v", out_v, 0);
    chk("abort_err", err, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_eng_rst", eng_rst, 1);
    chk("abort_out_data", out_data, 0);
    chk("abort_eng_row", eng_row, 0);
    err_model = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Randomized vectors, latencies, hangs and consumer stalls
    for (int j = 0; j < 15; j++) begin
      for (int k = 0; k < K; k++) begin
        la[k] = int'($urandom_range(1, 8));
        ha[k] = ($urandom_range(0, 5) == 0);
      end
      send(rand_vec(), la, ha, 1'b1, 1'b1, 1'b1);
    end
    drain();
    repeat (3) @(negedge clk);
    finish_sim();
  end

endmodule
